spi_loopback_top: RTL and testbench

//  Self-contained SPI round-trip subsystem: SPI master "A" and SPI slave "B" joined by internal SCLK/MOSI/MISO/CS_N.
//  A sends a 32-bit word to B. B increments it by one and returns the result to A in a second SPI frame.

---
 rtl/spi_loopback_top.sv | 195 +++++++++++++++++++
 tb/tb_spi_loopback_top.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/spi_loopback_top.sv
// SPI round-trip: master A sends a word to slave B, which returns word+1 in a second mode-0 frame.
// Optional `SPI_BUSY_PORT_EN adds a registered busy output.
module spi_loopback_top #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_A,
  output logic [DATA_W-1:0] out_data_B,
  output logic [DATA_W-1:0] out_data_A,
  output logic              done_A_to_B,
  output logic              response_ready,
  output logic              done_B_to_A
`ifdef SPI_BUSY_PORT_EN
  ,
  output logic              busy
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] BIT_FULL = CNT_W'(DATA_W);

  typedef enum logic [2:0] {A_IDLE, A_TX, A_WAIT, A_RX, A_DONE} a_state_e;
  typedef enum logic [2:0] {B_IDLE, B_RX, B_PROC, B_LOADED, B_TX} b_state_e;

  // Shared SPI wires
  logic sclk_q, cs_n_q, mosi_q, miso_q;

  // Master A
  a_state_e          a_st_q;
  logic [DATA_W-1:0] last_sent_q, a_tx_q, a_rx_q, out_data_A_q;
  logic [DIV_W-1:0]  div_q;
  logic [CNT_W-1:0]  bit_q;
  logic              sample_q, done_B_to_A_q, busy_q;

  // Slave B
  b_state_e          b_st_q;
  logic [DATA_W-1:0] b_rx_q, b_tx_q, out_data_B_q, resp_d;
  logic [CNT_W-1:0]  b_cnt_q;
  logic              sclk_prev_q, cs_prev_q, done_A_to_B_q, response_ready_q;

  logic launch_d, sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_comb begin
    launch_d  = (a_st_q == A_IDLE) && (in_data_A != last_sent_q);
    sclk_rise = sclk_q & ~sclk_prev_q;
    sclk_fall = ~sclk_q & sclk_prev_q;
    cs_rise   = cs_n_q & ~cs_prev_q;
    cs_fall   = ~cs_n_q & cs_prev_q;
    resp_d    = out_data_B_q + DATA_W'(1);
  end

  // A samples MISO one clk after raising SCLK, giving B's registered MISO time to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_st_q        <= A_IDLE;
      last_sent_q   <= '0;
      a_tx_q        <= '0;
      a_rx_q        <= '0;
      out_data_A_q  <= '0;
      div_q         <= '0;
      bit_q         <= '0;
      sample_q      <= 1'b0;
      done_B_to_A_q <= 1'b0;
      busy_q        <= 1'b0;
      sclk_q        <= 1'b0;
      cs_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (a_st_q == A_RX && sample_q) a_rx_q <= {a_rx_q[DATA_W-2:0], miso_q};
      case (a_st_q)
        A_IDLE: if (launch_d) begin
          last_sent_q   <= in_data_A;
          a_tx_q        <= in_data_A;
          mosi_q        <= in_data_A[DATA_W-1];
          cs_n_q        <= 1'b0;
          div_q         <= '0;
          bit_q         <= '0;
          done_B_to_A_q <= 1'b0;
          busy_q        <= 1'b1;
          a_st_q        <= A_TX;
        end
        A_TX, A_RX: begin
          if (div_q == DIV_LAST) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
            if (!sclk_q) begin
              sample_q <= (a_st_q == A_RX);
            end else if (bit_q == BIT_LAST) begin
              cs_n_q <= 1'b1;
              mosi_q <= 1'b0;
              a_st_q <= (a_st_q == A_TX) ? A_WAIT : A_DONE;
            end else begin
              bit_q <= bit_q + 1'b1;
              if (a_st_q == A_TX) begin
                a_tx_q <= a_tx_q << 1;
                mosi_q <= a_tx_q[DATA_W-2];
              end
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        A_WAIT: if (response_ready_q) begin
          cs_n_q <= 1'b0;
          div_q  <= '0;
          bit_q  <= '0;
          a_st_q <= A_RX;
        end
        A_DONE: begin
          out_data_A_q  <= a_rx_q;
          done_B_to_A_q <= 1'b1;
          busy_q        <= 1'b0;
          a_st_q        <= A_IDLE;
        end
        default: a_st_q <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_st_q           <= B_IDLE;
      b_rx_q           <= '0;
      b_tx_q           <= '0;
      b_cnt_q          <= '0;
      out_data_B_q     <= '0;
      done_A_to_B_q    <= 1'b0;
      response_ready_q <= 1'b0;
      sclk_prev_q      <= 1'b0;
      cs_prev_q        <= 1'b1;
      miso_q           <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_q;
      cs_prev_q   <= cs_n_q;
      if (launch_d) begin
        done_A_to_B_q    <= 1'b0;
        response_ready_q <= 1'b0;
      end
      case (b_st_q)
        B_IDLE: if (cs_fall) begin
          b_cnt_q <= '0;
          b_st_q  <= B_RX;
        end
        B_RX: begin
          if (cs_rise) begin
            // Short frames are dropped without touching outputs or flags.
            if (b_cnt_q == BIT_FULL) begin
              out_data_B_q  <= b_rx_q;
              done_A_to_B_q <= 1'b1;
              b_st_q        <= B_PROC;
            end else begin
              b_st_q <= B_IDLE;
            end
          end else if (sclk_rise) begin
            b_rx_q  <= {b_rx_q[DATA_W-2:0], mosi_q};
            b_cnt_q <= b_cnt_q + 1'b1;
          end
        end
        B_PROC: begin
          b_tx_q           <= resp_d;
          miso_q           <= resp_d[DATA_W-1];
          response_ready_q <= 1'b1;
          b_st_q           <= B_LOADED;
        end
        B_LOADED: if (cs_fall) b_st_q <= B_TX;
        B_TX: begin
          if (cs_rise) begin
            miso_q <= 1'b0;
            b_st_q <= B_IDLE;
          end else if (sclk_fall) begin
            b_tx_q <= b_tx_q << 1;
            miso_q <= b_tx_q[DATA_W-2];
          end
        end
        default: b_st_q <= B_IDLE;
      endcase
    end
  end

  assign out_data_B     = out_data_B_q;
  assign out_data_A     = out_data_A_q;
  assign done_A_to_B    = done_A_to_B_q;
  assign response_ready = response_ready_q;
  assign done_B_to_A    = done_B_to_A_q;
`ifdef SPI_BUSY_PORT_EN
  assign busy           = busy_q;
`endif

endmodule

// File: tb/tb_spi_loopback_top.sv
// Directed bench for spi_loopback_top: CLK_DIV=2 main instance plus a CLK_DIV=1 instance for timing.
module tb_spi_loopback_top;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data_A = '0;
  logic [31:0] out_data_B, out_data_A;
  logic        done_A_to_B, response_ready, done_B_to_A;

  logic        rst1 = 1'b1;
  logic [31:0] in1 = '0;
  logic [31:0] out_B1, out_A1;
  logic        dab1, rr1, dba1;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  spi_loopback_top #(.DATA_W(32), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .in_data_A(in_data_A),
    .out_data_B(out_data_B), .out_data_A(out_data_A),
    .done_A_to_B(done_A_to_B), .response_ready(response_ready), .done_B_to_A(done_B_to_A)
  );

  spi_loopback_top #(.DATA_W(32), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data_A(in1),
    .out_data_B(out_B1), .out_data_A(out_A1),
    .done_A_to_B(dab1), .response_ready(rr1), .done_B_to_A(dba1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a word (releasing reset on the same negedge) and track when each flag first rises.
  task automatic run_txn(input logic [31:0] w, output int lat, output int tab,
                         output int trr, output int tba, output logic [2:0] clr);
    @(negedge clk);
    in_data_A = w;
    rst = 1'b0;
    tab = -1; trr = -1; tba = -1; clr = 3'b111;
    for (int n = 1; n <= 400 && tba < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) clr = {done_A_to_B, response_ready, done_B_to_A};
      if (tab < 0 && done_A_to_B)    tab = n;
      if (trr < 0 && response_ready) trr = n;
      if (tba < 0 && done_B_to_A)    tba = n;
    end
    lat = (tba < 0) ? -1 : tba - 1;
  endtask

  task automatic wait_done(input logic lvl, input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge clk); #1;
      if (done_B_to_A === lvl) ok = 1'b1;
    end
    if (!ok) begin
      fails++;
      $error("FAIL wait_done: done_B_to_A did not reach %0b within %0d clk", lvl, budget);
    end
  endtask

  initial begin
    int lat, tab, trr, tba, lat1;
    logic [2:0] clr;
    logic ok, stayed;

    // Reset held 5 clk
    repeat (5) @(posedge clk);
    #1;
    chk("rst_out_B", out_data_B, 32'h0);
    chk("rst_out_A", out_data_A, 32'h0);
    chk("rst_dAB", done_A_to_B, 1'b0);
    chk("rst_rr", response_ready, 1'b0);
    chk("rst_dBA", done_B_to_A, 1'b0);

    // 1: basic round trip on reset release
    run_txn(32'h3F801234, lat, tab, trr, tba, clr);
    $display("[TB] latency CLK_DIV=2: %0d clk", lat);
    chk("t1_lat_le_264", (lat >= 256 && lat <= 264), 1'b1);
    chk("t1_out_B", out_data_B, 32'h3F801234);
    chk("t1_out_A", out_data_A, 32'h3F801235);

    // 2: wrap
    run_txn(32'hFFFFFFFF, lat, tab, trr, tba, clr);
    chk("t2_out_B", out_data_B, 32'hFFFFFFFF);
    chk("t2_out_A", out_data_A, 32'h00000000);

    // 3: flag clearing and ordering
    run_txn(32'h42C80000, lat, tab, trr, tba, clr);
    chk("t3_cleared", clr, 3'b000);
    chk("t3_order_ab_rr", (tab > 0 && tab < trr), 1'b1);
    chk("t3_order_rr_ba", (trr > 0 && trr < tba), 1'b1);
    chk("t3_out_A", out_data_A, 32'h42C80001);

    // 4: input change mid frame 1, then rewrite of the same value
    @(negedge clk);
    in_data_A = 32'h11111111;
    repeat (40) @(negedge clk);
    in_data_A = 32'h22222222;
    wait_done(1'b1, 400, ok);
    chk("t4_first_done", ok, 1'b1);
    chk("t4_first_B", out_data_B, 32'h11111111);
    chk("t4_first_A", out_data_A, 32'h11111112);
    wait_done(1'b0, 10, ok);
    chk("t4_relaunch", ok, 1'b1);
    wait_done(1'b1, 400, ok);
    chk("t4_second_done", ok, 1'b1);
    chk("t4_second_A", out_data_A, 32'h22222223);
    @(negedge clk);
    in_data_A = 32'h22222222;
    stayed = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      stayed = stayed & done_B_to_A;
    end
    chk("t4_no_retransfer", stayed, 1'b1);
    chk("t4_hold_A", out_data_A, 32'h22222223);

    // 5: reset halfway through frame 2
    @(negedge clk);
    in_data_A = 32'h12345678;
    repeat (196) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_out_B", out_data_B, 32'h0);
    chk("t5_rst_out_A", out_data_A, 32'h0);
    chk("t5_rst_dAB", done_A_to_B, 1'b0);
    chk("t5_rst_rr", response_ready, 1'b0);
    chk("t5_rst_dBA", done_B_to_A, 1'b0);
    @(negedge clk);
    in_data_A = 32'h0000ABCD;
    run_txn(32'h0000ABCD, lat, tab, trr, tba, clr);
    chk("t5_done", (tba > 0), 1'b1);
    chk("t5_out_B", out_data_B, 32'h0000ABCD);
    chk("t5_out_A", out_data_A, 32'h0000ABCE);

    // 6: CLK_DIV=1 instance roughly halves the latency
    @(negedge clk);
    in1 = 32'h3F801234;
    rst1 = 1'b0;
    lat1 = -1;
    for (int n = 1; n <= 300 && lat1 < 0; n++) begin
      @(posedge clk); #1;
      if (dba1) lat1 = n - 1;
    end
    $display("[TB] latency CLK_DIV=1: %0d clk", lat1);
    chk("t6_lat1_range", (lat1 >= 128 && lat1 <= 140), 1'b1);
    chk("t6_halves", (lat1 > 0 && lat1 * 2 <= lat + 16), 1'b1);
    chk("t6_out_B1", out_B1, 32'h3F801234);
    chk("t6_out_A1", out_A1, 32'h3F801235);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
